// File: rtl/slt_bist_pkg.sv
// Shared types, golden result constants and expectation helper for the
// set-less-than compare unit BIST.
package slt_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } slt_bist_state_t;

  localparam logic [7:0] RES_LT = 8'h80;
  localparam logic [7:0] RES_GE = 8'h00;

  typedef struct packed {
    logic       check;
    logic [7:0] word;
  } slt_exp_t;

  // Equal operands yield an undefined result, so they are flagged as unchecked.
  function automatic slt_exp_t slt_expect(input logic [31:0] a, input logic [31:0] b);
    slt_exp_t r;
    r.check = (a != b);
    r.word  = (a < b) ? RES_LT : RES_GE;
    return r;
  endfunction

endpackage

// File: rtl/slt_bist.sv
// BIST initiator: sweeps every {a, b} operand pair through the compare unit,
// counts mismatches against the golden word and records the first failing pair.
module slt_bist
  import slt_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int RES_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic [RES_W-1:0]   y_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int IW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  slt_bist_state_t state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [IW:0]      err_q, err_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  slt_exp_t         exp_s;
  logic [RES_W-1:0] golden;
  logic             mismatch;

  // Golden word is left-aligned so its MSB lands on the result MSB (RES_W >= 8).
  always_comb begin
    exp_s    = slt_expect(32'(idx_q[IW-1:WIDTH]), 32'(idx_q[WIDTH-1:0]));
    golden   = RES_W'(exp_s.word) << (RES_W - 8);
    mismatch = exp_s.check && (y_in != golden);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          idx_d    = '0;
          settle_d = '0;
          err_d    = '0;
          fa_d     = '0;
          fb_d     = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fa_d = idx_q[IW-1:WIDTH];
            fb_d = idx_q[WIDTH-1:0];
          end
        end
        if (idx_q == '1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign a_out     = idx_q[IW-1:WIDTH];
  assign b_out     = idx_q[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;

endmodule

// File: tb/tb_slt_bist.sv
// Bench for slt_bist: behavioural compare-unit models with injectable faults,
// a default-parameter instance and a SETTLE=3 instance.
module tb_slt_bist;

  logic       clk = 1'b0;
  logic       rst, start1, start2;
  logic [3:0] a1, b1, a2, b2, fa1, fb1, fa2, fb2;
  logic [7:0] y1, y2;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [8:0] err1, err2;

  int         mode;
  logic [7:0] corr [256];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // mode 0 good, 1 stuck 00, 2 stuck 80, 3 returns 81 for a<b, 4 MSB inverted, 5 random corruption
  function automatic logic [7:0] unit_model(int m, logic [3:0] a, logic [3:0] b, logic [7:0] c);
    logic [7:0] g;
    g = (a < b) ? 8'h80 : 8'h00;
    case (m)
      1:       return 8'h00;
      2:       return 8'h80;
      3:       return (a < b) ? 8'h81 : 8'h00;
      4:       return g ^ 8'h80;
      5:       return g ^ c;
      default: return g;
    endcase
  endfunction

  always_comb y1 = unit_model(mode, a1, b1, corr[{a1, b1}]);
  always_comb y2 = unit_model(0, a2, b2, 8'h00);

  slt_bist dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1)
  );

  slt_bist #(.WIDTH(4), .RES_W(8), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(fa2), .fail_b(fb2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".busy"}, busy1, 0);
    check({tag, ".done"}, done1, 0);
    check({tag, ".pass"}, pass1, 0);
    check({tag, ".err"},  err1,  0);
    check({tag, ".fa"},   fa1,   0);
    check({tag, ".fb"},   fb1,   0);
    check({tag, ".a"},    a1,    0);
    check({tag, ".b"},    b1,    0);
  endtask

  // Run a sweep on dut1; optional mid-sweep start pulse and optional reset abort.
  task automatic run1(input int pulse_at, input int abort_at, output int cyc);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1;
    check("accept.busy", busy1, 1);
    check("accept.done", done1, 0);
    @(negedge clk) start1 = 1'b0;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == pulse_at)     start1 = 1'b1;
      if (cyc == pulse_at + 1) start1 = 1'b0;
      if (abort_at != 0 && cyc == abort_at) begin
        rst = 1'b1;
        #1;
        return;
      end
      if (done1) break;
      if (cyc > 6000) begin
        check("timeout1", 0, 1);
        break;
      end
    end
    check("end.busy", busy1, 0);
  endtask

  typedef struct {
    int mode;
    int err;
    int fa;
    int fb;
    bit pass;
  } vec_t;

  vec_t tab[5];

  initial begin
    int cyc, run, ref_err, ref_first;
    logic [7:0] prev;

    tab[0] = '{0, 0,   0, 0, 1'b1};
    tab[1] = '{1, 120, 0, 1, 1'b0};
    tab[2] = '{2, 120, 1, 0, 1'b0};
    tab[3] = '{3, 120, 0, 1, 1'b0};
    tab[4] = '{4, 240, 0, 1, 1'b0};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 0;
    for (int i = 0; i < 256; i++) corr[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      mode = tab[v].mode;
      run1(0, 0, cyc);
      check($sformatf("v%0d.cycles", v), cyc, 512);
      check($sformatf("v%0d.err", v), err1, tab[v].err);
      check($sformatf("v%0d.pass", v), pass1, tab[v].pass);
      check($sformatf("v%0d.done", v), done1, 1);
      if (tab[v].err != 0) begin
        check($sformatf("v%0d.fa", v), fa1, tab[v].fa);
        check($sformatf("v%0d.fb", v), fb1, tab[v].fb);
      end
    end

    for (int r = 0; r < 3; r++) begin
      mode = 5;
      ref_err = 0;
      ref_first = -1;
      for (int i = 0; i < 256; i++) begin
        corr[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        if ((i / 16) != (i % 16) && corr[i] != 8'h00) begin
          ref_err++;
          if (ref_first < 0) ref_first = i;
        end
      end
      run1(0, 0, cyc);
      check($sformatf("rnd%0d.cycles", r), cyc, 512);
      check($sformatf("rnd%0d.err", r), err1, ref_err);
      check($sformatf("rnd%0d.pass", r), pass1, (ref_err == 0));
      if (ref_err != 0) begin
        check($sformatf("rnd%0d.fa", r), fa1, ref_first / 16);
        check($sformatf("rnd%0d.fb", r), fb1, ref_first % 16);
      end
    end

    mode = 1;
    run1(0, 200, cyc);
    check_reset_vals("midrst");
    @(negedge clk) rst = 1'b0;
    mode = 2;
    run1(100, 0, cyc);
    check("restart.cycles", cyc, 512);
    check("restart.err", err1, 120);
    check("restart.fa", fa1, 1);
    check("restart.fb", fb1, 0);
    check("restart.pass", pass1, 0);

    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1;
    check("s3.accept.busy", busy2, 1);
    @(negedge clk) start2 = 1'b0;
    prev = {a2, b2};
    run = 1;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done2 || cyc > 6000) break;
      @(negedge clk);
      if ({a2, b2} != prev) begin
        check("s3.hold", run, 4);
        run = 1;
        prev = {a2, b2};
      end else begin
        run++;
      end
    end
    check("s3.cycles", cyc, 1024);
    check("s3.err", err2, 0);
    check("s3.pass", pass2, 1);
    check("s3.busy", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
